// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// ---------------------------------------------------------------------------
// Issue-side controller for the arithmetic execute unit. It takes one ready
// operation from the reservation station and pulses start to the execute
// unit. It waits for the done pulse, then holds the tagged result on the CDB
// until the arbiter grants it. Only one operation is in flight at a time.
//
// Optional feature macro: ALU_ISSUE_WDOG_EN
//   When this macro is defined, a watchdog counts the cycles spent in WAIT and
//   DRAIN. After TIMEOUT_CYCLES cycles without done, it sets the sticky
//   wdog_err flag and returns the controller to IDLE with no broadcast.
//   When the macro is undefined, wdog_err is tied to 0.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   in_valid/in_ready            reservation-station handshake
//   in_op/in_vala/in_valb/
//   in_valhw/in_tag              operation captured on accept
//   flush                        squash of the in-flight operation
//   start                        one-cycle start pulse to the execute unit
//   ALUop/alu_vala/alu_valb/
//   alu_valhw                    operands held for the execute unit
//   res/done                     execute unit result and completion pulse
//   cdb_valid/cdb_ready          CDB request and grant
//   cdb_tag/cdb_data             broadcast tag and result
//   wdog_err                     sticky watchdog error flag
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [63:0]      in_vala,
    input  logic [63:0]      in_valb,
    input  logic [5:0]       in_valhw,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             start,
    output logic [4:0]       ALUop,
    output logic [63:0]      alu_vala,
    output logic [63:0]      alu_valb,
    output logic [5:0]       alu_valhw,
    input  logic [63:0]      res,
    input  logic             done,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [63:0]      cdb_data,
    output logic             wdog_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        BCAST = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [4:0]       op_q;
    logic [63:0]      vala_q;
    logic [63:0]      valb_q;
    logic [5:0]       valhw_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      data_q;
    logic             wdog_fire;

    wire accept    = (state_q == IDLE) && in_valid;
    // The result is kept only if it arrives in WAIT with no flush in the
    // same cycle. A flush on the same cycle as done discards the result.
    wire keep_res  = (state_q == WAIT) && done && !flush;

`ifdef ALU_ISSUE_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wdog_cnt;
    logic             wdog_err_q;

    // A done pulse on the final count wins over the timeout.
    assign wdog_fire = ((state_q == WAIT) || (state_q == DRAIN)) && !done &&
                       (wdog_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The counter restarts whenever the state changes. So entering WAIT, and
    // moving from WAIT into DRAIN, both begin a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (state_d != state_q)
                wdog_cnt <= '0;
            else if ((state_q == WAIT) || (state_q == DRAIN))
                wdog_cnt <= wdog_cnt + CNT_W'(1);
            if (wdog_fire)
                wdog_err_q <= 1'b1;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wdog_fire      = 1'b0;
    assign wdog_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = ISSUE;
            // start pulses in ISSUE whether or not a flush is present.
            ISSUE:   state_d = flush ? DRAIN : WAIT;
            WAIT: begin
                if (done)
                    state_d = flush ? IDLE : BCAST;
                else if (flush)
                    state_d = DRAIN;
            end
            // The execute unit cannot abort, so wait for its done and drop it.
            DRAIN:   if (done) state_d = IDLE;
            BCAST:   if (cdb_ready || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wdog_fire)
            state_d = IDLE;
    end

    // Operand and result holding registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            vala_q  <= '0;
            valb_q  <= '0;
            valhw_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                op_q    <= in_op;
                vala_q  <= in_vala;
                valb_q  <= in_valb;
                valhw_q <= in_valhw;
                tag_q   <= in_tag;
            end
            if (keep_res)
                data_q <= res;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign start     = (state_q == ISSUE);
    assign cdb_valid = (state_q == BCAST);
    assign ALUop     = op_q;
    assign alu_vala  = vala_q;
    assign alu_valb  = valb_q;
    assign alu_valhw = valhw_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    localparam int TAG_W = 4;
    localparam int TOUT  = 8;
`ifdef ALU_ISSUE_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid, in_ready, flush, start, done, cdb_valid, cdb_ready, wdog_err;
    logic [4:0]       in_op, ALUop;
    logic [63:0]      in_vala, in_valb, alu_vala, alu_valb, res, cdb_data;
    logic [5:0]       in_valhw, alu_valhw;
    logic [TAG_W-1:0] in_tag, cdb_tag;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_vala(in_vala), .in_valb(in_valb), .in_valhw(in_valhw), .in_tag(in_tag),
        .flush(flush), .start(start), .ALUop(ALUop),
        .alu_vala(alu_vala), .alu_valb(alu_valb), .alu_valhw(alu_valhw),
        .res(res), .done(done),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .wdog_err(wdog_err)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: the life of one operation, tracked as flags
    bit               m_busy, m_issue, m_wait, m_squash, m_res, m_werr;
    int               m_cnt;
    logic [4:0]       m_op;
    logic [63:0]      m_a, m_b, m_d;
    logic [5:0]       m_hw;
    logic [TAG_W-1:0] m_tag;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_issue = 0; m_wait = 0; m_squash = 0; m_res = 0; m_werr = 0;
            m_cnt = 0; m_op = '0; m_a = '0; m_b = '0; m_d = '0; m_hw = '0; m_tag = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_issue = 1;
                m_op = in_op; m_a = in_vala; m_b = in_valb; m_hw = in_valhw; m_tag = in_tag;
            end
        end else if (m_issue) begin
            m_issue = 0; m_wait = 1; m_squash = flush; m_cnt = 0;
        end else if (m_wait) begin
            if (WDOG && !done && m_cnt == TOUT - 1) begin
                m_wait = 0; m_busy = 0; m_werr = 1;
            end else if (done) begin
                m_wait = 0;
                if (m_squash || flush) m_busy = 0;
                else begin m_res = 1; m_d = res; end
            end else if (flush && !m_squash) begin
                m_squash = 1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (m_res) begin
            if (cdb_ready || flush) begin m_res = 0; m_busy = 0; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready",  64'(in_ready),  64'(!m_busy));
            chk("m_start",     64'(start),     64'(m_issue));
            chk("m_cdb_valid", 64'(cdb_valid), 64'(m_res));
            chk("m_wdog_err",  64'(wdog_err),  64'(m_werr));
            chk("m_ALUop",     64'(ALUop),     64'(m_op));
            chk("m_alu_vala",  alu_vala,       m_a);
            chk("m_alu_valb",  alu_valb,       m_b);
            chk("m_alu_valhw", 64'(alu_valhw), 64'(m_hw));
            if (m_res) begin
                chk("m_cdb_tag",  64'(cdb_tag), 64'(m_tag));
                chk("m_cdb_data", cdb_data,     m_d);
            end
        end
    end

    // Directed single operation with a stub latency L, checked with literals
    task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] tag, input int lat, input logic [63:0] r);
        @(negedge clk);
        chk("op_idle_ready", 64'(in_ready), 64'd1);
        in_valid = 1; in_op = op; in_vala = a; in_valb = b; in_valhw = 6'd0; in_tag = tag;
        @(negedge clk);
        in_valid = 0;
        chk("op_start", 64'(start), 64'd1);
        chk("op_busy", 64'(in_ready), 64'd0);
        chk("op_aluop", 64'(ALUop), 64'(op));
        chk("op_vala", alu_vala, a);
        repeat (lat) @(negedge clk);
        chk("op_start_once", 64'(start), 64'd0);
        chk("op_no_early_cdb", 64'(cdb_valid), 64'd0);
        done = 1; res = r;
        @(negedge clk);
        done = 0; res = '0;
        chk("op_cdb_valid", 64'(cdb_valid), 64'd1);
        chk("op_cdb_tag", 64'(cdb_tag), 64'(tag));
        chk("op_cdb_data", cdb_data, r);
        cdb_ready = 1;
        @(negedge clk);
        cdb_ready = 0;
        chk("op_cdb_drop", 64'(cdb_valid), 64'd0);
        chk("op_ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        in_valid = 0; in_op = '0; in_vala = '0; in_valb = '0; in_valhw = '0; in_tag = '0;
        flush = 0; done = 0; res = '0; cdb_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_wdog", 64'(wdog_err), 64'd0);
        chk("rst_cdb_data", cdb_data, 64'd0);
        rst = 1; chk_en = 1;

        // Add example: 1 + 1 = 2 on tag 3, with latency 1
        run_op(5'd0, 64'd1, 64'd1, 4'd3, 1, 64'd2);

        // CDB backpressure
        @(negedge clk);
        in_valid = 1; in_op = 5'd5; in_vala = 64'd7; in_valb = 64'd9; in_tag = 4'd9;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        done = 1; res = 64'h1234_5678_9abc_def0;
        @(negedge clk);
        done = 0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(cdb_valid), 64'd1);
            chk("bp_data", cdb_data, 64'h1234_5678_9abc_def0);
            chk("bp_tag", 64'(cdb_tag), 64'd9);
            chk("bp_busy", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        chk("bp_valid_last", 64'(cdb_valid), 64'd1);
        cdb_ready = 1;
        @(negedge clk);
        cdb_ready = 0;
        chk("bp_one_xfer", 64'(cdb_valid), 64'd0);
        chk("bp_ready", 64'(in_ready), 64'd1);

        // Flush in WAIT, with stub latency 4: done arrives at cycle 5
        in_valid = 1; in_op = 5'd2; in_tag = 4'd4;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("fl_no_cdb3", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        chk("fl_no_cdb4", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        chk("fl_busy", 64'(in_ready), 64'd0);
        done = 1; res = 64'd77;
        @(negedge clk);
        done = 0;
        chk("fl_ready_after_done", 64'(in_ready), 64'd1);
        chk("fl_no_cdb6", 64'(cdb_valid), 64'd0);

        // Spurious done while idle
        done = 1; res = 64'hDEAD;
        @(negedge clk);
        done = 0; res = '0;
        chk("sp_no_cdb", 64'(cdb_valid), 64'd0);
        chk("sp_idle", 64'(in_ready), 64'd1);
        chk("sp_no_start", 64'(start), 64'd0);

        // Reset asserted during WAIT
        in_valid = 1; in_op = 5'd9; in_vala = 64'd5; in_valb = 64'd6; in_valhw = 6'd3; in_tag = 4'd2;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_start", 64'(start), 64'd0);
        chk("ar_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("ar_aluop", 64'(ALUop), 64'd0);
        chk("ar_vala", alu_vala, 64'd0);
        chk("ar_valhw", 64'(alu_valhw), 64'd0);
        chk("ar_cdb_tag", 64'(cdb_tag), 64'd0);
        @(negedge clk);
        rst = 1;
        run_op(5'd3, 64'd100, 64'd200, 4'd7, 2, 64'd300);

`ifdef ALU_ISSUE_WDOG_EN
        // Watchdog test: the stub never responds
        @(negedge clk);
        in_valid = 1; in_op = 5'd1; in_tag = 4'd1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            in_valid = 0;
            chk("wd_not_yet", 64'(wdog_err), 64'd0);
        end
        @(negedge clk);
        chk("wd_set", 64'(wdog_err), 64'd1);
        chk("wd_idle", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("wd_sticky", 64'(wdog_err), 64'd1);
`endif

        // Randomized traffic, checked each cycle against the model
        repeat (4000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_op     = 5'($urandom);
            in_vala   = {$urandom, $urandom};
            in_valb   = {$urandom, $urandom};
            in_valhw  = 6'($urandom);
            in_tag    = TAG_W'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            done      = ($urandom_range(0, 3) == 0);
            res       = {$urandom, $urandom};
            cdb_ready = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        in_valid = 0; flush = 0; done = 0; cdb_ready = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
